// File: rtl/life_sequencer_if.sv
// Request/board/status bundle between the Life sequencer and its environment.
// master drives requests and the board image; slave is the sequencer itself.
interface life_sequencer_if;
  localparam int unsigned BOARD_W = 64;
  localparam int unsigned RATE_W  = 4;
  localparam int unsigned GEN_W   = 16;
  localparam int unsigned RSD_W   = 8;

  logic               run;
  logic               step;
  logic               reseed;
  logic [RATE_W-1:0]  rate_sel;
  logic [BOARD_W-1:0] board_in;
  logic               game_en;
  logic               load_seed;
  logic               lfsr_en;
  logic               halted;
  logic [GEN_W-1:0]   gen_count;
  logic [RSD_W-1:0]   reseed_count;

  modport master (
    output run, step, reseed, rate_sel, board_in,
    input  game_en, load_seed, lfsr_en, halted, gen_count, reseed_count
  );

  modport slave (
    input  run, step, reseed, rate_sel, board_in,
    output game_en, load_seed, lfsr_en, halted, gen_count, reseed_count
  );
endinterface

// File: rtl/life_sequencer.sv
// Control FSM sequencing the 64-cell Life core and its LFSR seed source.
// Define LIFE_AUTO_RESEED_EN to reseed automatically instead of halting on a stable board.
module life_sequencer #(
  parameter int unsigned DIV_BASE    = 4,
  parameter int unsigned STABLE_GENS = 3
) (
  input  logic             clk,
  input  logic             reset,
  life_sequencer_if.slave  bus
);

  localparam int unsigned DIV_W   = 20;
  localparam int unsigned BOARD_W = 64;
  localparam int unsigned GEN_W   = 16;
  localparam int unsigned RSD_W   = 8;
  localparam int unsigned HIST_W  = 2;
  localparam int unsigned STB_W   = $clog2(STABLE_GENS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PAUSE, S_WAIT, S_ADV, S_EVAL, S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic               step_s_q, step_p_q, rsd_s_q, rsd_p_q;
  logic               pend_q, pend_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [STB_W-1:0]   stable_q, stable_d;
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [BOARD_W-1:0] prev1_q, prev1_d, prev2_q, prev2_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic [RSD_W-1:0]   rsd_cnt_q, rsd_cnt_d;
  logic               game_en_q, load_seed_q, lfsr_en_q, halted_q;

  logic               step_edge, rsd_edge, rsd_req, tick, match;
  logic [DIV_W-1:0]   period_m1;

  // Inputs pass a sync stage before edge detection, so requests act two clocks later.
  assign step_edge = step_s_q & ~step_p_q;
  assign rsd_edge  = rsd_s_q & ~rsd_p_q;
  assign rsd_req   = rsd_edge | pend_q;
  assign period_m1 = (DIV_W'(DIV_BASE) << bus.rate_sel) - DIV_W'(1);
  assign tick      = (div_q == period_m1);
  assign match     = (bus.board_in == '0) ||
                     ((hist_q == HIST_W'(2)) &&
                      ((bus.board_in == prev1_q) || (bus.board_in == prev2_q)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_s_q    <= 1'b0;
      step_p_q    <= 1'b0;
      rsd_s_q     <= 1'b0;
      rsd_p_q     <= 1'b0;
      pend_q      <= 1'b0;
      div_q       <= '0;
      stable_q    <= '0;
      hist_q      <= '0;
      prev1_q     <= '0;
      prev2_q     <= '0;
      gen_q       <= '0;
      rsd_cnt_q   <= '0;
      game_en_q   <= 1'b0;
      load_seed_q <= 1'b0;
      lfsr_en_q   <= 1'b1;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_s_q    <= bus.step;
      step_p_q    <= step_s_q;
      rsd_s_q     <= bus.reseed;
      rsd_p_q     <= rsd_s_q;
      pend_q      <= pend_d;
      div_q       <= div_d;
      stable_q    <= stable_d;
      hist_q      <= hist_d;
      prev1_q     <= prev1_d;
      prev2_q     <= prev2_d;
      gen_q       <= gen_d;
      rsd_cnt_q   <= rsd_cnt_d;
      game_en_q   <= (state_d == S_ADV);
      load_seed_q <= (state_d == S_LOAD);
      lfsr_en_q   <= (state_d == S_IDLE) || (state_d == S_PAUSE) ||
                     (state_d == S_WAIT) || (state_d == S_HALT);
      halted_q    <= (state_d == S_HALT);
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    div_d     = '0;
    stable_d  = stable_q;
    hist_d    = hist_q;
    prev1_d   = prev1_q;
    prev2_d   = prev2_q;
    gen_d     = gen_q;
    rsd_cnt_d = rsd_cnt_q;

    // A reseed edge while the core is busy waits for the next idle-ish state.
    if (((state_q == S_ADV) || (state_q == S_EVAL)) && rsd_edge) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rsd_req) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d  = S_PAUSE;
        gen_d    = '0;
        stable_d = '0;
        hist_d   = '0;
        prev1_d  = '0;
        prev2_d  = '0;
      end
      S_PAUSE: begin
        if (rsd_req)        state_d = S_LOAD;
        else if (step_edge) state_d = S_ADV;
        else if (bus.run)   state_d = S_WAIT;
      end
      S_WAIT: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (rsd_req)       state_d = S_LOAD;
        else if (!bus.run) state_d = S_PAUSE;
        else if (tick)     state_d = S_ADV;
      end
      S_ADV: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        stable_d = match ? STB_W'(stable_q + STB_W'(1)) : '0;
        prev2_d  = prev1_q;
        prev1_d  = bus.board_in;
        hist_d   = (hist_q == HIST_W'(2)) ? hist_q : hist_q + HIST_W'(1);
        gen_d    = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
        if (stable_d == STB_W'(STABLE_GENS)) begin
`ifdef LIFE_AUTO_RESEED_EN
          state_d   = S_LOAD;
          rsd_cnt_d = rsd_cnt_q + RSD_W'(1);
`else
          state_d   = S_HALT;
`endif
        end else if (bus.run) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_HALT: begin
        if (rsd_req) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_LOAD) pend_d = 1'b0;
  end

  assign bus.game_en      = game_en_q;
  assign bus.load_seed    = load_seed_q;
  assign bus.lfsr_en      = lfsr_en_q;
  assign bus.halted       = halted_q;
  assign bus.gen_count    = gen_q;
  assign bus.reseed_count = rsd_cnt_q;

endmodule

// File: doc/life_sequencer.md
Name: life_sequencer

Overview:
- Control FSM that sequences the 64-cell Conway game core and the 64-bit LFSR seed source.
- Decides when the LFSR free-runs, when a seed is loaded into the game, and when the game advances one generation.
- Advances at a programmable rate, or one generation per step request.
- Detects still-life, period-2 and empty boards and halts, or auto-reseeds when the optional feature is compiled in.

Parameters:
- DIV_BASE, 4, base tick period in clk cycles; effective period = DIV_BASE << rate_sel (DIV_BASE >= 1).
- STABLE_GENS, 3, consecutive matching generations required to declare the board stable (>= 1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- run  input  1  level; 1 = free-run generations
- step  input  1  request one generation; rising-edge detected internally
- reseed  input  1  request a new seed; rising-edge detected internally
- rate_sel  input  4  speed select, shift amount on DIV_BASE
- board_in  input  64  current game board (game core output)
- game_en  output  1  one-cycle pulse; game core computes the next generation
- load_seed  output  1  one-cycle pulse; game core loads the LFSR value
- lfsr_en  output  1  LFSR shift enable
- halted  output  1  board declared stable; game frozen
- gen_count  output  16  generations since last seed load; saturates at 16'hFFFF
- reseed_count  output  8  auto-reseeds performed; wraps at 8 bits (0 when the feature is off)

Behaviour:
- States: IDLE, LOAD, PAUSE, WAIT, ADV, EVAL, HALT.
- Outputs are Moore-decoded from the state register.
  - game_en = 1 only in ADV.
  - load_seed = 1 only in LOAD.
  - lfsr_en = 1 in IDLE, PAUSE, WAIT and HALT; 0 in LOAD, ADV and EVAL.
  - halted = 1 only in HALT.
- Reset values: state IDLE, gen_count 0, reseed_count 0, history registers 0, divider 0, edge-detect registers 0, stable_cnt 0, hist_valid 0. Outputs at reset are therefore game_en 0, load_seed 0, lfsr_en 1, halted 0.
- Request priority, same cycle: reseed edge > step edge > run.
- IDLE: reseed edge -> LOAD. All other inputs are ignored.
- LOAD (1 cycle) -> PAUSE. Also clears gen_count, stable_cnt, hist_valid, prev1 and prev2.
- PAUSE:
  - reseed edge -> LOAD
  - else step edge -> ADV
  - else run = 1 -> WAIT
- WAIT:
  - Divider counts up from 0. tick when divider == (DIV_BASE << rate_sel) - 1; divider is computed 20 bits wide.
  - Divider clears on every entry to WAIT and whenever tick fires.
  - reseed edge -> LOAD; else run = 0 -> PAUSE; else tick -> ADV.
  - A step edge in WAIT is dropped.
- ADV (1 cycle) -> EVAL. board_in is valid with the new generation in EVAL.
- EVAL (1 cycle):
  - match = (board_in == 0) OR (hist_valid == 2 AND (board_in == prev1 OR board_in == prev2)).
  - stable_cnt increments on match, otherwise clears to 0.
  - Update order: prev2 <= prev1, prev1 <= board_in, hist_valid saturates at 2, gen_count increments (saturating).
  - Exit: if the updated stable_cnt == STABLE_GENS -> HALT; else run = 1 -> WAIT; else PAUSE.
- HALT: reseed edge -> LOAD. run and step are ignored.
- A reseed edge arriving during ADV or EVAL is held in a pending flag and serviced at the next PAUSE, WAIT or HALT state. At most one reseed is pending.
- Changing rate_sel mid-count takes effect on the next compare. If the divider already exceeds the new period - 1, it keeps counting up to the 20-bit wrap and then matches the new period.
- Asynchronous reset at any point returns to IDLE within the same cycle. Outputs drop immediately.

Optional Feature:
- Macro: LIFE_AUTO_RESEED_EN.
- When defined:
  - EVAL-stable goes to LOAD instead of HALT, and reseed_count increments (8-bit wrap).
  - HALT is unreachable, so halted stays 0.
- When undefined:
  - Behaviour is as above; reseed_count is tied to 0.

Test Plan:
- Reset, then a reseed pulse -> load_seed high for exactly 1 cycle, 2 clocks after the reseed rising edge. Then PAUSE with lfsr_en = 1 and gen_count = 0.
- PAUSE, step held high for 10 cycles -> exactly one game_en pulse and gen_count = 1. lfsr_en = 0 during the ADV and EVAL cycles.
- DIV_BASE = 4, rate_sel = 1, run = 1 for 100 cycles with a changing board -> game_en pulses every 10 cycles (8 WAIT + ADV + EVAL), and gen_count = 10.
- Board model holds 64'h0000_0018_1800_0000 constant, STABLE_GENS = 3, run = 1 -> halted asserts after EVAL of generation 5 (two fills + three matches), and game_en stops.
- Board model returns 64'h0 -> halted after generation 3. With LIFE_AUTO_RESEED_EN defined: LOAD occurs instead, reseed_count = 1, halted stays 0.
- reseed and step rising in the same cycle in PAUSE -> LOAD taken and no game_en. Reset asserted mid-WAIT -> next cycle shows state IDLE, gen_count 0 and lfsr_en 1.
